// File: rtl/add_subt_final_pack.sv
`default_nettype none
// ============================================================================
// add_subt_final_pack : FP add/sub back end - round, range check, IEEE-754 pack
// Macro FINAL_ROUND_EN adds the round-to-nearest-even state.       Rev 1.0
// ============================================================================
module add_subt_final_pack #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          sgn_final_result_i,
  input  logic          zero_flag_i,
  input  logic [EW:0]   exp_i,
  input  logic [SW+3:0] mant_i,
  input  logic          ack_i,
  output logic [W-1:0]  final_result_o,
  output logic          ready_o,
  output logic          busy_o,
  output logic          overflow_flag_o,
  output logic          underflow_flag_o
);

  localparam logic [1:0] IDLE  = 2'd0;
`ifdef FINAL_ROUND_EN
  localparam logic [1:0] ROUND = 2'd1;
`endif
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [EW:0] EXP_MAX = {1'b0, {EW{1'b1}}};

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          load;
  logic          do_pack;
  logic          sgn_reg;
  logic          zero_reg;
  logic [EW:0]   exp_reg;
  logic [SW+3:0] mant_reg;
  logic [W-1:0]  pack_result;
  logic          pack_ovf;
  logic          pack_unf;

`ifdef FINAL_ROUND_EN
  logic          do_round;
  logic          round_up;
  logic [SW+1:0] rnd_sum;

  // mant_reg = {hidden, fraction, G, R, S}; bit 3 is the fraction LSB
  assign round_up = mant_reg[2] & (mant_reg[1] | mant_reg[0] | mant_reg[3]);
  assign rnd_sum  = {1'b0, mant_reg[SW+3:3]} + {{(SW+1){1'b0}}, round_up};
`else
  logic          unused_grs;
  assign unused_grs = ^mant_reg[2:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef FINAL_ROUND_EN
      IDLE:    if (start_i) state_nxt = ROUND;
      ROUND:   state_nxt = CHECK;
`else
      IDLE:    if (start_i) state_nxt = CHECK;
`endif
      CHECK:   state_nxt = DONE;
      DONE:    if (ack_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state != IDLE);
    ready_o  = (state == DONE);
    load     = (state == IDLE) && start_i;
    do_pack  = (state == CHECK);
`ifdef FINAL_ROUND_EN
    do_round = (state == ROUND);
`endif
  end

  // Range check in priority order: zero, overflow, underflow, normal
  always_comb begin
    pack_result = {sgn_reg, exp_reg[EW-1:0], mant_reg[SW+2:3]};
    pack_ovf    = 1'b0;
    pack_unf    = 1'b0;
    if (zero_reg) begin
      pack_result = '0;
    end else if (exp_reg >= EXP_MAX) begin
      pack_result = {sgn_reg, {EW{1'b1}}, {SW{1'b0}}};
      pack_ovf    = 1'b1;
    end else if ((exp_reg == '0) || !mant_reg[SW+3]) begin
      pack_result = {sgn_reg, {(EW+SW){1'b0}}};
      pack_unf    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sgn_reg          <= 1'b0;
      zero_reg         <= 1'b0;
      exp_reg          <= '0;
      mant_reg         <= '0;
      final_result_o   <= '0;
      overflow_flag_o  <= 1'b0;
      underflow_flag_o <= 1'b0;
    end else begin
      if (load) begin
        sgn_reg  <= sgn_final_result_i;
        zero_reg <= zero_flag_i;
        exp_reg  <= exp_i;
        mant_reg <= mant_i;
      end
`ifdef FINAL_ROUND_EN
      if (do_round) begin
        if (rnd_sum[SW+1]) begin
          mant_reg[SW+3:3] <= rnd_sum[SW+1:1];
          exp_reg          <= exp_reg + {{EW{1'b0}}, 1'b1};
        end else begin
          mant_reg[SW+3:3] <= rnd_sum[SW:0];
        end
      end
`endif
      if (do_pack) begin
        final_result_o   <= pack_result;
        overflow_flag_o  <= pack_ovf;
        underflow_flag_o <= pack_unf;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/add_subt_final_pack.md
Name: add_subt_final_pack

Overview:
Back-end stage of the floating-point add/subtract unit. It is the counterpart of the operand-start front end: that stage unpacks the operands and classifies them, and this stage packs the result. It takes the result sign, the zero flag, the biased exponent and the normalized mantissa with guard/round/sticky bits. It rounds, checks for exponent overflow/underflow, and assembles the IEEE-754 word. The result is presented with a ready/ack handshake to the FPU output register.

Parameters:
W, 32, total word width (32 single, 64 double)
EW, 8, exponent field width (8 single, 11 double)
SW, 23, fraction field width (23 single, 52 double); W = 1+EW+SW required

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
start_i  in  1  one-cycle pulse: inputs valid, begin pack
sgn_final_result_i  in  1  result sign from front end
zero_flag_i  in  1  effective subtraction of equal magnitudes
exp_i  in  EW+1  biased exponent; extra MSB carries overflow
mant_i  in  SW+4  {hidden, fraction[SW-1:0], G, R, S}
ack_i  in  1  consumer accepted result
final_result_o  out  W  packed IEEE-754 result
ready_o  out  1  final_result_o valid
busy_o  out  1  high in any state except IDLE
overflow_flag_o  out  1  result saturated to infinity
underflow_flag_o  out  1  result flushed to zero

Behaviour:
- rst low, asynchronous: state IDLE. All outputs 0 and all internal registers 0.
- FSM states: IDLE, ROUND, CHECK, DONE.
- IDLE:
  - busy_o=0.
  - When start_i=1, latch sgn, zero, exp and mant into internal registers and go to ROUND.
- ROUND:
  - Round to nearest even. Round up when G & (R | S | fraction LSB).
  - Add 1 to {hidden, fraction} in an SW+2-bit sum.
  - On carry-out, shift the sum right by 1 and increment exp by 1 (EW+1-bit add).
  - Go to CHECK.
- CHECK: priority order, first match wins:
  - zero flag → result +0 (all bits 0), flags 0.
  - exp >= 2^EW-1 → {sgn, all ones, zeros} (infinity), overflow_flag_o=1.
  - exp == 0 or hidden == 0 → {sgn, zeros}, underflow_flag_o=1. Denormals are not produced.
  - Otherwise → {sgn, exp[EW-1:0], fraction}.
  - final_result_o and flags are registered on the CHECK→DONE transition. Go to DONE.
- DONE:
  - ready_o=1; final_result_o and flags held stable.
  - On ack_i=1, go to IDLE. ready_o is 0 on the following cycle.
- Latency: start_i sampled in cycle N → ready_o=1 in cycle N+3.
- start_i is ignored in ROUND, CHECK and DONE, including start_i and ack_i high together in DONE. Such a start is dropped and must be re-issued in IDLE.
- ack_i outside DONE has no effect.
- final_result_o and flags keep their last value after ack until the next CHECK→DONE. Flags are cleared on each new CHECK.
- rst low mid-operation aborts to IDLE with all outputs 0.

Optional Feature:
Macro FINAL_ROUND_EN.
- Defined: ROUND state present; round-to-nearest-even as above; latency 3.
- Undefined: ROUND state removed; G/R/S ignored (truncation); IDLE goes directly to CHECK; latency 2.

Test Plan:
- Normal pack (W=32, FINAL_ROUND_EN): start_i with sgn=0, exp=0x07F, mant={1, 0x400000, 3'b000} → final_result_o=0x3FC00000 and ready_o=1 exactly 3 cycles after start, flags 0.
- Round carry: sgn=0, exp=0x07F, mant={1, 0x7FFFFF, 3'b100} → 0x40000000 (exponent incremented to 0x80).
- Tie to even: exp=0x07F, mant={1, 0x000000, 3'b100} → 0x3F800000 (no increment). The same with fraction 0x000001 → 0x3F800002.
- Overflow and zero:
  - sgn=1, exp=0x0FF, mant={1, 0, 000} → 0xFF800000, overflow_flag_o=1.
  - zero_flag_i=1, sgn=1 → 0x00000000.
  - exp=0x000 → 0x80000000 with sgn=1, underflow_flag_o=1.
- Handshake: hold ack_i=0 for 5 cycles in DONE → ready_o and result stable. Pulse start_i in DONE together with ack_i → start dropped, FSM in IDLE, busy_o=0.
- Reset: drive rst low during ROUND → ready_o=0, busy_o=0, final_result_o=0 immediately. After rst is released, a new start completes normally.
